// File: rtl/cam_serializer_pkg.sv
// Shared types and elaboration helpers for the camera-port stream serializer.
//  - cs_state_t      : frame engine states
//  - BEAT_CNT_W      : width of the per-state beat counter (covers up to 64 beats)
//  - beats_per_word  : number of bus beats needed to send one word
//  - is_pow2         : used to reject illegal FIFO depths at elaboration
package cam_serializer_pkg;

  typedef enum logic [1:0] {
    CS_IDLE,
    CS_DATA,
    CS_SYNC,
    CS_PAD
  } cs_state_t;

  localparam int BEAT_CNT_W = 6;

  function automatic int beats_per_word(input int data_w, input int bus_w);
    return data_w / bus_w;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/cam_sync_fifo.sv
// Single-clock word FIFO with a first-word-fall-through head.
// Pointers are one bit wider than the address so full and empty can be told
// apart by the pointer MSBs alone.
//  clk_i  in   system clock
//  rst_n  in   synchronous reset, active low (empties the FIFO)
//  push   in   write wdata (caller guarantees space, or a same-cycle pop)
//  wdata  in   word to store
//  pop    in   drop the head word (caller guarantees non-empty)
//  head   out  oldest stored word, valid whenever empty is low
//  full   out  DEPTH words stored
//  empty  out  no words stored
//  level  out  number of words stored
module cam_sync_fifo
  import cam_serializer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [DATA_W-1:0]              wdata,
  input  logic                           pop,
  output logic [DATA_W-1:0]              head,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     level
);

  localparam int AW = $clog2(DEPTH);

  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("cam_sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wptr_q;
  logic [AW:0]       rptr_q;

  // NOTE: clocked state is always assigned with <= so every flop samples the
  // pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // define which entries are valid, so clearing the array buys nothing.
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr_q[AW-1:0]] <= wdata;
  end

  // On a full FIFO a push and pop in the same cycle touch the same entry:
  // the head is read combinationally before the edge, then overwritten.
  assign head  = mem[rptr_q[AW-1:0]];
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level = wptr_q - rptr_q;

endmodule

// File: rtl/cam_stream_serializer.sv
// Sends queued words to the ESP32 over its camera (DVP) port. Each word goes
// out least-significant beat first, followed by one VSYNC beat and PAD_BEATS
// idle beats. All frame registers move on the divider strobe, so cam_data
// changes just after cam_pclk falls.
//  clk_i         in   system clock
//  rst_n         in   synchronous reset, active low
//  wr_i          in   push data_i this cycle
//  data_i        in   word to send
//  clr_ovf_i     in   clears overflow_o and drop_count_o
//  full_o        out  FIFO holds DEPTH words
//  level_o       out  queued words, excluding the word in flight
//  busy          out  word in flight or FIFO non-empty
//  overflow_o    out  sticky: a write was dropped
//  drop_count_o  out  dropped writes, saturating
//  cam_pclk      out  camera pixel clock
//  cam_sync      out  VSYNC, high for the sync beat only
//  cam_data      out  beat data
module cam_stream_serializer
  import cam_serializer_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int BUS_W       = 4,
  parameter int DEPTH       = 8,
  parameter int COUNT_WIDTH = 2,
  parameter int PAD_BEATS   = 1,
  parameter int GATE_PCLK   = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_n,
  input  logic                           wr_i,
  input  logic [DATA_W-1:0]              data_i,
  input  logic                           clr_ovf_i,
  output logic                           full_o,
  output logic [$clog2(DEPTH+1)-1:0]     level_o,
  output logic                           busy,
  output logic                           overflow_o,
  output logic [15:0]                    drop_count_o,
  output logic                           cam_pclk,
  output logic                           cam_sync,
  output logic [BUS_W-1:0]               cam_data
);

  localparam int NB = beats_per_word(DATA_W, BUS_W);
  localparam logic [BEAT_CNT_W-1:0] DATA_LAST = BEAT_CNT_W'(NB - 1);
  localparam logic [BEAT_CNT_W-1:0] PAD_LAST  =
    BEAT_CNT_W'((PAD_BEATS > 0) ? PAD_BEATS - 1 : 0);

  if ((DATA_W % BUS_W) != 0) begin : g_bad_width
    $error("cam_stream_serializer: DATA_W must be a multiple of BUS_W");
  end
  if (NB > 64) begin : g_bad_nb
    $error("cam_stream_serializer: at most 64 beats per word");
  end
  if (PAD_BEATS < 0 || PAD_BEATS > 7) begin : g_bad_pad
    $error("cam_stream_serializer: PAD_BEATS must be 0..7");
  end

  // ---------------------------------------------------------------- divider
  logic [COUNT_WIDTH-1:0] div_q;
  logic                   beat_stb;
  logic                   clkdiv;

  always_ff @(posedge clk_i) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= div_q + 1'b1;
  end

  assign beat_stb = (div_q == '0);
  assign clkdiv   = div_q[COUNT_WIDTH-1];

  // ------------------------------------------------------------------- FIFO
  logic              fifo_push;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              drop;

  // A write against a full FIFO still lands if the engine pops this cycle.
  assign fifo_push = wr_i & (~fifo_full | fifo_pop);
  assign drop      = wr_i &   fifo_full & ~fifo_pop;

  cam_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (data_i),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level_o)
  );

  assign full_o = fifo_full;

  // -------------------------------------------------------------- frame FSM
  cs_state_t              state_q, state_d;
  logic [DATA_W-1:0]      sreg_q, sreg_d;
  logic [BEAT_CNT_W-1:0]  beat_q, beat_d;
  logic                   load_next;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q <= CS_IDLE;
      sreg_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    sreg_d    = sreg_q;
    beat_d    = beat_q;
    fifo_pop  = 1'b0;
    load_next = 1'b0;
    cam_data  = '0;
    cam_sync  = 1'b0;
    cam_pclk  = clkdiv & ((state_q != CS_IDLE) | (GATE_PCLK == 0));

    unique case (state_q)
      CS_DATA: cam_data = sreg_q[BUS_W-1:0];
      CS_SYNC: cam_sync = 1'b1;
      default: ;
    endcase

    if (beat_stb) begin
      unique case (state_q)
        CS_IDLE: load_next = 1'b1;
        CS_DATA: begin
          if (beat_q == DATA_LAST) begin
            state_d = CS_SYNC;
            beat_d  = '0;
          end else begin
            sreg_d = sreg_q >> BUS_W;
            beat_d = beat_q + 1'b1;
          end
        end
        CS_SYNC: begin
          if (PAD_BEATS > 0) begin
            state_d = CS_PAD;
            beat_d  = '0;
          end else begin
            load_next = 1'b1;
          end
        end
        CS_PAD: begin
          if (beat_q == PAD_LAST) load_next = 1'b1;
          else                    beat_d = beat_q + 1'b1;
        end
        default: state_d = CS_IDLE;
      endcase
    end

    // End of a frame (or idle strobe): start the next word straight away if
    // one is queued, so back-to-back frames carry no extra gap.
    if (load_next) begin
      if (!fifo_empty) begin
        state_d  = CS_DATA;
        sreg_d   = fifo_head;
        beat_d   = '0;
        fifo_pop = 1'b1;
      end else begin
        state_d  = CS_IDLE;
      end
    end
  end

  assign busy = (state_q != CS_IDLE) | (level_o != '0);

  // ---------------------------------------------------------- drop tracking
  logic        ovf_q;
  logic [15:0] drop_cnt_q;

  // A drop in the same cycle as a clear wins: the clear is consumed and the
  // new drop is counted from zero.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      ovf_q      <= 1'b1;
      if (clr_ovf_i)                 drop_cnt_q <= 16'd1;
      else if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end else if (clr_ovf_i) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end
  end

  assign overflow_o   = ovf_q;
  assign drop_count_o = drop_cnt_q;

endmodule

// File: tb/tb_cam_stream_serializer.sv
// Bench for cam_stream_serializer. Three instances share one clock:
//  a : default parameters
//  b : DEPTH=4 (overflow and full-FIFO pop behaviour)
//  c : DATA_W=16, BUS_W=8, PAD_BEATS=0, GATE_PCLK=0
// Beats are sampled on the falling clk edge right after cam_pclk rises,
// which is mid-beat as the ESP32 would see it.
module tb_cam_stream_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // instance a
  logic        rst_a = 1'b0, wr_a = 1'b0, clr_a = 1'b0;
  logic [31:0] data_a = '0;
  logic        full_a, busy_a, ovf_a, pclk_a, sync_a;
  logic [3:0]  level_a, cdata_a;
  logic [15:0] drop_a;
  // instance b
  logic        rst_b = 1'b0, wr_b = 1'b0, clr_b = 1'b0;
  logic [31:0] data_b = '0;
  logic        full_b, busy_b, ovf_b, pclk_b, sync_b;
  logic [2:0]  level_b;
  logic [3:0]  cdata_b;
  logic [15:0] drop_b;
  // instance c
  logic        rst_c = 1'b0, wr_c = 1'b0, clr_c = 1'b0;
  logic [15:0] data_c = '0;
  logic        full_c, busy_c, ovf_c, pclk_c, sync_c;
  logic [3:0]  level_c;
  logic [7:0]  cdata_c;
  logic [15:0] drop_c;

  cam_stream_serializer u_a (
    .clk_i(clk), .rst_n(rst_a), .wr_i(wr_a), .data_i(data_a), .clr_ovf_i(clr_a),
    .full_o(full_a), .level_o(level_a), .busy(busy_a), .overflow_o(ovf_a),
    .drop_count_o(drop_a), .cam_pclk(pclk_a), .cam_sync(sync_a), .cam_data(cdata_a)
  );

  cam_stream_serializer #(.DEPTH(4)) u_b (
    .clk_i(clk), .rst_n(rst_b), .wr_i(wr_b), .data_i(data_b), .clr_ovf_i(clr_b),
    .full_o(full_b), .level_o(level_b), .busy(busy_b), .overflow_o(ovf_b),
    .drop_count_o(drop_b), .cam_pclk(pclk_b), .cam_sync(sync_b), .cam_data(cdata_b)
  );

  cam_stream_serializer #(.DATA_W(16), .BUS_W(8), .PAD_BEATS(0), .GATE_PCLK(0)) u_c (
    .clk_i(clk), .rst_n(rst_c), .wr_i(wr_c), .data_i(data_c), .clr_ovf_i(clr_c),
    .full_o(full_c), .level_o(level_c), .busy(busy_c), .overflow_o(ovf_c),
    .drop_count_o(drop_c), .cam_pclk(pclk_c), .cam_sync(sync_c), .cam_data(cdata_c)
  );

  // Word and the beat sequence expected on the wire, first beat in the MS nibble.
  typedef struct {
    logic [31:0] word;
    logic [31:0] exp_seq;
  } vec_t;
  vec_t vecs [5];

  // ------------------------------------------------------------ helpers
  function automatic logic sel_pclk(input int w);
    case (w)
      0:       return pclk_a;
      1:       return pclk_b;
      default: return pclk_c;
    endcase
  endfunction

  function automatic logic sel_busy(input int w);
    case (w)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic [7:0] sel_data(input int w);
    case (w)
      0:       return {4'h0, cdata_a};
      1:       return {4'h0, cdata_b};
      default: return cdata_c;
    endcase
  endfunction

  function automatic logic sel_sync(input int w);
    case (w)
      0:       return sync_a;
      1:       return sync_b;
      default: return sync_c;
    endcase
  endfunction

  function automatic int sel_level(input int w);
    case (w)
      0:       return int'(level_a);
      1:       return int'(level_b);
      default: return int'(level_c);
    endcase
  endfunction

  function automatic logic [63:0] outs(input int w);
    case (w)
      0:       return 64'({pclk_a, sync_a, cdata_a, full_a, level_a, busy_a, ovf_a, drop_a});
      1:       return 64'({pclk_b, sync_b, cdata_b, full_b, level_b, busy_b, ovf_b, drop_b});
      default: return 64'({pclk_c, sync_c, cdata_c, full_c, level_c, busy_c, ovf_c, drop_c});
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no cam_pclk rise within bound", name);
  endtask

  // Drive one write; returns at the falling edge after the sampling edge.
  task automatic write_word(input int w, input logic [31:0] d);
    case (w)
      0:       begin wr_a = 1'b1; data_a = d; end
      1:       begin wr_b = 1'b1; data_b = d; end
      default: begin wr_c = 1'b1; data_c = d[15:0]; end
    endcase
    @(negedge clk);
    wr_a = 1'b0;
    wr_b = 1'b0;
    wr_c = 1'b0;
  endtask

  // Reset one instance; returns just before the first edge after release.
  task automatic reset_inst(input int w);
    case (w)
      0:       rst_a = 1'b0;
      1:       rst_b = 1'b0;
      default: rst_c = 1'b0;
    endcase
    @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;
  endtask

  // Wait for the next rising cam_pclk and sample the beat.
  task automatic get_beat(input int w, output logic [7:0] d, output logic s, output bit ok);
    logic prev, cur;
    prev = sel_pclk(w);
    ok = 1'b0;
    d  = '0;
    s  = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      cur = sel_pclk(w);
      if (cur && !prev) begin
        d  = sel_data(w);
        s  = sel_sync(w);
        ok = 1'b1;
        break;
      end
      prev = cur;
    end
  endtask

  // Capture a whole frame: nb data beats, one sync beat, pad idle beats.
  task automatic capture_frame(input int w, input int nb, input int pad, input int bw,
                               output logic [63:0] seq, output logic [15:0] syncv,
                               output logic [7:0] tail, output int t0, output int lvl0,
                               output bit ok);
    logic [7:0] d;
    logic       s;
    seq = '0; syncv = '0; tail = '0; t0 = 0; lvl0 = -1;
    for (int k = 0; k < nb + 1 + pad; k++) begin
      get_beat(w, d, s, ok);
      if (!ok) begin
        timeout("frame_beat");
        return;
      end
      if (k == 0) begin
        t0   = cyc;
        lvl0 = sel_level(w);
      end
      if (k < nb) seq = (seq << bw) | 64'(d);
      else        tail = tail | d;
      syncv = {syncv[14:0], s};
    end
  endtask

  // PCLK must stay gated low and busy clear for a while.
  task automatic idle_check(input int w, input string name);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (sel_pclk(w) || sel_busy(w)) cnt++;
    end
    check(name, 64'(cnt), 64'd0);
  endtask

  // ---------------------------------------------------------------- test
  initial begin
    logic [63:0] seq;
    logic [15:0] syncv;
    logic [7:0]  tail;
    logic [7:0]  d;
    logic        s;
    int          t0, t_prev, lvl0, rises;
    bit          ok;
    logic [31:0] t2_exp [3];
    logic        prev;

    vecs[0] = '{word: 32'h87654321, exp_seq: 32'h12345678};
    vecs[1] = '{word: 32'hDEADBEEF, exp_seq: 32'hFEEBDAED};
    vecs[2] = '{word: 32'h0000000A, exp_seq: 32'hA0000000};
    vecs[3] = '{word: 32'hF0000000, exp_seq: 32'h0000000F};
    vecs[4] = '{word: 32'h13579BDF, exp_seq: 32'hFDB97531};

    // Reset state while rst_n held low.
    repeat (3) @(negedge clk);
    check("reset_outputs_a", outs(0), 64'd0);
    check("reset_outputs_b", outs(1), 64'd0);
    check("reset_outputs_c", outs(2), 64'd0);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    @(negedge clk);

    // T1 plus table: single word from idle, full frame, then gated idle.
    for (int v = 0; v < 5; v++) begin
      write_word(0, vecs[v].word);
      check($sformatf("busy_after_wr[%0d]", v), 64'(busy_a), 64'd1);
      capture_frame(0, 8, 1, 4, seq, syncv, tail, t0, lvl0, ok);
      if (!ok) break;
      check($sformatf("frame_data[%0d]", v), seq, 64'(vecs[v].exp_seq));
      check($sformatf("sync_pattern[%0d]", v), 64'(syncv[9:0]), 64'h002);
      check($sformatf("sync_pad_data[%0d]", v), 64'(tail), 64'd0);
      repeat (4) @(negedge clk);
      idle_check(0, $sformatf("gated_idle[%0d]", v));
    end

    // T2: three back-to-back writes; divider phase fixed by a fresh reset so
    // the writes land on edges 2..4 and the first pop on edge 5.
    t2_exp[0] = 32'h11111111;
    t2_exp[1] = 32'h22222222;
    t2_exp[2] = 32'h33333333;
    reset_inst(0);
    @(negedge clk);
    write_word(0, 32'h11111111);
    write_word(0, 32'h22222222);
    write_word(0, 32'h33333333);
    check("t2_level_3", 64'(level_a), 64'd3);
    t_prev = 0;
    for (int f = 0; f < 3; f++) begin
      capture_frame(0, 8, 1, 4, seq, syncv, tail, t0, lvl0, ok);
      if (!ok) break;
      check($sformatf("t2_data[%0d]", f), seq, 64'(t2_exp[f]));
      check($sformatf("t2_sync[%0d]", f), 64'(syncv[9:0]), 64'h002);
      check($sformatf("t2_level_at_start[%0d]", f), 64'(lvl0), 64'(2 - f));
      if (f > 0) check($sformatf("t2_frame_spacing[%0d]", f), 64'(t0 - t_prev), 64'd40);
      t_prev = t0;
    end
    repeat (4) @(negedge clk);
    idle_check(0, "t2_gated_idle");

    // T3: DEPTH=4. Writes on edges 2..8; edge 5 pops the first word, so
    // words 6 and 7 hit a full FIFO and are dropped.
    reset_inst(1);
    @(negedge clk);
    for (int i = 0; i < 7; i++) write_word(1, 32'hA0000000 + 32'(i));
    check("t3_full", 64'(full_b), 64'd1);
    check("t3_level", 64'(level_b), 64'd4);
    check("t3_overflow", 64'(ovf_b), 64'd1);
    check("t3_drop_count", 64'(drop_b), 64'd2);
    clr_b = 1'b1;
    @(negedge clk);              // edge 9
    clr_b = 1'b0;
    check("t3_clr_overflow", 64'(ovf_b), 64'd0);
    check("t3_clr_drop_count", 64'(drop_b), 64'd0);
    check("t3_level_after_clr", 64'(level_b), 64'd4);

    // T6: frame 1 started on edge 5 (8 data + sync + pad beats of 4 edges),
    // so the next pop is on edge 45. A write on edge 44 drops; one on 45 lands.
    repeat (34) @(negedge clk);  // now after edge 43
    write_word(1, 32'hB0000000); // edge 44: full, no pop
    check("t6_drop_before_pop", 64'(drop_b), 64'd1);
    write_word(1, 32'hB0000001); // edge 45: full, pop
    check("t6_coincident_drop_count", 64'(drop_b), 64'd1);
    check("t6_coincident_level", 64'(level_b), 64'd4);
    check("t6_full", 64'(full_b), 64'd1);

    // T4: reset during beat 4 of a frame with one more word queued.
    write_word(0, 32'h87654321);
    write_word(0, 32'h11111111);
    for (int k = 0; k < 5; k++) begin
      get_beat(0, d, s, ok);
      if (!ok) begin
        timeout("t4_beat");
        break;
      end
    end
    check("t4_beat4_data", 64'(d), 64'd5);
    check("t4_level_before", 64'(level_a), 64'd1);
    rst_a = 1'b0;
    @(negedge clk);
    check("t4_reset_outputs", outs(0), 64'd0);
    rst_a = 1'b1;
    idle_check(0, "t4_no_resume");
    write_word(0, vecs[0].word);
    capture_frame(0, 8, 1, 4, seq, syncv, tail, t0, lvl0, ok);
    if (ok) begin
      check("t4_fresh_frame_data", seq, 64'(vecs[0].exp_seq));
      check("t4_fresh_frame_sync", 64'(syncv[9:0]), 64'h002);
    end

    // T5: 16-bit word on an 8-bit bus, no pad, free-running PCLK. Written on
    // edge 2 after reset, popped on edge 5; the first rise seen is edge 6.
    reset_inst(2);
    @(negedge clk);
    write_word(2, 32'h0000BEEF);
    capture_frame(2, 2, 0, 8, seq, syncv, tail, t0, lvl0, ok);
    if (ok) begin
      check("t5_frame_data", seq, 64'hEFBE);
      check("t5_sync", 64'(syncv[2:0]), 64'b001);
      check("t5_sync_data", 64'(tail), 64'd0);
    end
    repeat (4) @(negedge clk);
    rises = 0;
    prev  = pclk_c;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (pclk_c && !prev) rises++;
      prev = pclk_c;
    end
    check("t5_idle_pclk_rises", 64'(rises), 64'd4);
    check("t5_idle_busy", 64'(busy_c), 64'd0);
    check("t5_idle_data", 64'({sync_c, cdata_c}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
